// File: rtl/divremsqrtintiter_pkg.sv
// Shared divider package: configuration record and divider state types.
package divremsqrtintiter_pkg;

  typedef struct packed {
    int unsigned XLEN;
    int unsigned INTDIVb;
  } cvw_t;

  localparam cvw_t CVW_DEFAULT = '{XLEN: 64, INTDIVb: 64};

  typedef enum logic [1:0] {
    DIVIDLE,
    DIVBUSY,
    DIVDONE
  } divstate_t;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } divintstate_t;

endpackage

// File: rtl/divremsqrtintstep.sv
// One radix-2 restoring division step on the {rem, quo} shift pair.
module divremsqrtintstep
  import divremsqrtintiter_pkg::*;
#(
  parameter cvw_t P = CVW_DEFAULT
) (
  input  logic [P.XLEN-1:0] rem,
  input  logic [P.XLEN-1:0] quo,
  input  logic [P.XLEN-1:0] babs,
  output logic [P.XLEN-1:0] remnext,
  output logic [P.XLEN-1:0] quonext
);
  localparam int XLEN = P.XLEN;

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            ge;

  // The shifted remainder can exceed XLEN bits, so compare at XLEN+1;
  // when it fits, the modular XLEN-bit difference is the exact remainder.
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    ge      = shifted >= {1'b0, babs};
    diff    = shifted[XLEN-1:0] - babs;
    remnext = ge ? diff : shifted[XLEN-1:0];
    quonext = {quo[XLEN-2:0], ge};
  end

endmodule

// File: rtl/divremsqrtintiter.sv
// Iterative restoring integer divider feeding the integer special-case stage.
module divremsqrtintiter
  import divremsqrtintiter_pkg::*;
#(
  parameter cvw_t P = CVW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 StartE,
  input  logic                 FlushE,
  input  logic [P.XLEN-1:0]    AE,
  input  logic [P.XLEN-1:0]    BE,
  input  logic                 SignedE,
  input  logic                 RemOpE,
  output logic                 BusyE,
  output logic                 DoneM,
  output logic [P.XLEN-1:0]    AM,
  output logic [P.XLEN-1:0]    BM,
  output logic                 RemOpM,
  output logic                 BZeroM,
  output logic                 ALTBM,
  output logic [P.INTDIVb+3:0] PreIntResultM
);
  localparam int XLEN = P.XLEN;
  localparam int CW   = $clog2(XLEN) + 1;
  localparam int EXTW = P.INTDIVb + 4 - XLEN;

  divintstate_t    state;
  logic            signa, signb;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem, quo, babs;
  logic [XLEN-1:0] aabs_c, babs_c, remnext, quonext, qfix, rfix, res;
  logic            bzero_c, altb_c, lastiter;

  // Sign bits are only set for signed operations, so unsigned ops never negate.
  always_comb begin
    aabs_c   = signa ? -AM : AM;
    babs_c   = signb ? -BM : BM;
    bzero_c  = ~|BM;
    altb_c   = aabs_c < babs_c;
    qfix     = (signa ^ signb) ? -quo : quo;
    rfix     = signa ? -rem : rem;
    res      = RemOpM ? rfix : qfix;
    lastiter = cnt == CW'(XLEN - 1);
  end

  divremsqrtintstep #(.P(P)) ustep (
    .rem     (rem),
    .quo     (quo),
    .babs    (babs),
    .remnext (remnext),
    .quonext (quonext)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      BusyE         <= 1'b0;
      DoneM         <= 1'b0;
      AM            <= '0;
      BM            <= '0;
      RemOpM        <= 1'b0;
      BZeroM        <= 1'b0;
      ALTBM         <= 1'b0;
      PreIntResultM <= '0;
      cnt           <= '0;
      signa         <= 1'b0;
      signb         <= 1'b0;
      rem           <= '0;
      quo           <= '0;
      babs          <= '0;
    end else if (FlushE) begin
      state <= IDLE;
      BusyE <= 1'b0;
      DoneM <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (StartE) begin
            AM            <= AE;
            BM            <= BE;
            RemOpM        <= RemOpE;
            signa         <= SignedE & AE[XLEN-1];
            signb         <= SignedE & BE[XLEN-1];
            BZeroM        <= 1'b0;
            ALTBM         <= 1'b0;
            PreIntResultM <= '0;
            BusyE         <= 1'b1;
            state         <= PREP;
          end
        end
        PREP: begin
          BZeroM <= bzero_c;
          ALTBM  <= altb_c;
          if (bzero_c | altb_c) begin
            BusyE <= 1'b0;
            DoneM <= 1'b1;
            state <= DONE;
          end else begin
            rem   <= '0;
            quo   <= aabs_c;
            babs  <= babs_c;
            cnt   <= '0;
            state <= ITER;
          end
        end
        ITER: begin
          rem <= remnext;
          quo <= quonext;
          cnt <= cnt + CW'(1);
          if (lastiter) state <= FIX;
        end
        FIX: begin
          PreIntResultM <= {{EXTW{res[XLEN-1]}}, res};
          BusyE         <= 1'b0;
          DoneM         <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          DoneM <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divremsqrtintiter.sv
// Directed and random checks of the iterative integer divider against an arithmetic model.
module tb_divremsqrtintiter;
  import divremsqrtintiter_pkg::*;

  logic        clk = 1'b0;
  logic        resetn, StartE, FlushE, SignedE, RemOpE;
  logic [63:0] AE, BE;
  logic        BusyE, DoneM, RemOpM, BZeroM, ALTBM;
  logic [63:0] AM, BM;
  logic [67:0] PreIntResultM;

  int checks = 0;
  int errors = 0;

  divremsqrtintiter #(.P(CVW_DEFAULT)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .StartE        (StartE),
    .FlushE        (FlushE),
    .AE            (AE),
    .BE            (BE),
    .SignedE       (SignedE),
    .RemOpE        (RemOpE),
    .BusyE         (BusyE),
    .DoneM         (DoneM),
    .AM            (AM),
    .BM            (BM),
    .RemOpM        (RemOpM),
    .BZeroM        (BZeroM),
    .ALTBM         (ALTBM),
    .PreIntResultM (PreIntResultM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division on magnitudes / signed longints.
  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic s,
                                input logic r, output logic [67:0] res, output logic bz,
                                output logic altb, output int lat);
    logic [63:0] ma, mb, q, rm, v;
    ma   = (s && a[63]) ? -a : a;
    mb   = (s && b[63]) ? -b : b;
    bz   = (b == 64'd0);
    altb = ma < mb;
    if (bz || altb) begin
      res = '0;
      lat = 2;
    end else begin
      lat = 67;
      if (!s) begin
        q  = a / b;
        rm = a % b;
      end else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
        q  = a;
        rm = '0;
      end else begin
        q  = $signed(a) / $signed(b);
        rm = $signed(a) % $signed(b);
      end
      v   = r ? rm : q;
      res = {{4{v[63]}}, v};
    end
  endfunction

  // Caller sits 1 time unit after an edge; StartE is sampled at the next edge (edge 0).
  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic s, input logic r);
    AE = a; BE = b; SignedE = s; RemOpE = r; StartE = 1'b1;
    @(posedge clk); #1;
    StartE = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic s, input logic r);
    logic [67:0] eres, held;
    logic ebz, ealtb;
    int elat, cyc;
    model(a, b, s, r, eres, ebz, ealtb, elat);
    start_op(a, b, s, r);
    chk({tag, ".busy1"}, {67'd0, BusyE}, 68'd1);
    cyc = 1;
    while (!DoneM && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".latency"}, 68'(cyc), 68'(elat));
    chk({tag, ".result"}, PreIntResultM, eres);
    chk({tag, ".bzero"}, {67'd0, BZeroM}, {67'd0, ebz});
    chk({tag, ".altb"}, {67'd0, ALTBM}, {67'd0, ealtb});
    chk({tag, ".am"}, {4'd0, AM}, {4'd0, a});
    chk({tag, ".bm"}, {4'd0, BM}, {4'd0, b});
    chk({tag, ".remop"}, {67'd0, RemOpM}, {67'd0, r});
    chk({tag, ".busydone"}, {67'd0, BusyE}, 68'd0);
    held = PreIntResultM;
    @(posedge clk); #1;
    chk({tag, ".donepulse"}, {67'd0, DoneM}, 68'd0);
    chk({tag, ".hold"}, PreIntResultM, eres);
    chk({tag, ".holdam"}, {4'd0, AM}, {4'd0, a});
    if (held !== eres) $display("note: %s result changed after done", tag);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".busy"}, {67'd0, BusyE}, 68'd0);
    chk({tag, ".done"}, {67'd0, DoneM}, 68'd0);
    chk({tag, ".am"}, {4'd0, AM}, 68'd0);
    chk({tag, ".bm"}, {4'd0, BM}, 68'd0);
    chk({tag, ".flags"}, {65'd0, RemOpM, BZeroM, ALTBM}, 68'd0);
    chk({tag, ".result"}, PreIntResultM, 68'd0);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic sawdone;
    resetn = 1'b0; StartE = 1'b0; FlushE = 1'b0; SignedE = 1'b0; RemOpE = 1'b0;
    AE = '0; BE = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    resetn = 1'b1;
    @(posedge clk); #1;

    run_check("udiv", 64'd100, 64'd7, 1'b0, 1'b0);
    run_check("srem", -64'd100, 64'd7, 1'b1, 1'b1);
    run_check("sdiv", -64'd100, 64'd7, 1'b1, 1'b0);
    run_check("divzero", 64'd1234, 64'd0, 1'b0, 1'b0);
    run_check("small", 64'd3, 64'd5, 1'b0, 1'b0);
    run_check("ssmall", -64'd3, 64'd5, 1'b1, 1'b0);
    run_check("ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run_check("ovfrem", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    run_check("umax", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    run_check("uneg", 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b0, 1'b1);

    for (int i = 0; i < 24; i++) begin
      ra = {$urandom, $urandom};
      rb = (i % 3 == 0) ? {$urandom, $urandom} : 64'($urandom_range(1, 100000));
      if (i % 4 == 1) rb = -rb;
      run_check($sformatf("rand%0d", i), ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Flush mid-operation: no DoneM, idle next cycle, then a fresh start completes.
    start_op(64'd5000, 64'd3, 1'b0, 1'b0);
    sawdone = 1'b0;
    for (int c = 1; c < 20; c++) begin
      if (DoneM) sawdone = 1'b1;
      @(posedge clk); #1;
    end
    FlushE = 1'b1;
    @(posedge clk); #1;
    FlushE = 1'b0;
    chk("flush.busy", {67'd0, BusyE}, 68'd0);
    if (DoneM) sawdone = 1'b1;
    @(posedge clk); #1;
    if (DoneM) sawdone = 1'b1;
    chk("flush.nodone", {67'd0, sawdone}, 68'd0);
    run_check("afterflush", 64'd5000, 64'd3, 1'b0, 1'b1);

    // Reset mid-operation.
    start_op(64'd99999, 64'd11, 1'b1, 1'b0);
    sawdone = 1'b0;
    for (int c = 1; c < 30; c++) begin
      if (DoneM) sawdone = 1'b1;
      @(posedge clk); #1;
    end
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("rstmid.nodone", {67'd0, sawdone}, 68'd0);
    chk_reset_vals("rstmid");
    resetn = 1'b1;
    @(posedge clk); #1;
    run_check("afterrst", 64'd99999, 64'd11, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/divremsqrtintiter.md
# divremsqrtintiter

Iterative radix-2 restoring integer divider that sits directly upstream of the integer special-case stage in the divide/remainder/square-root unit. It accepts an integer divide or remainder operation in the E stage, runs a multi-cycle start/busy/done handshake, and computes the raw sign-corrected quotient or remainder. It also produces the divide-by-zero and small-numerator flags and the registered operands that the special-case stage consumes in the M stage.

## Interface
Parameters:
- P: cvw_t configuration record. Uses P.XLEN (operand width) and P.INTDIVb (result field width).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- StartE  in  1  start request; accepted only in IDLE
- FlushE  in  1  abort the operation in flight
- AE, BE  in  XLEN  dividend and divisor
- SignedE  in  1  1 = signed operation, 0 = unsigned
- RemOpE  in  1  1 = remainder, 0 = quotient
- BusyE  out  1  operation in progress; stalls the pipeline
- DoneM  out  1  one-cycle pulse; result valid
- AM, BM  out  XLEN  registered operands
- RemOpM  out  1  registered RemOpE
- BZeroM  out  1  BM == 0
- ALTBM  out  1  |A| < |B| (unsigned magnitude for unsigned ops)
- PreIntResultM  out  INTDIVb+4  result; low XLEN bits valid, upper bits sign-extended from bit XLEN-1

## Operation
- States are IDLE, PREP, ITER, FIX and DONE.
- **IDLE:** when StartE = 1, capture AE, BE, SignedE and RemOpE into AM, BM, RemOpM and the internal sign bits, then go to PREP.
- **PREP:**
  - Compute magnitudes |A| and |B|. Negation applies only when SignedE = 1 and the MSB is set.
  - Compute BZeroM and ALTBM.
  - If BZeroM or ALTBM is set, go to DONE directly (early out). Otherwise load the remainder register with 0 and the quotient register with |A|, clear the counter, and go to ITER.
- **ITER:**
  - Each cycle, shift {rem, quo} left by 1 and trial-subtract |B| from rem.
  - If the result is non-negative, keep the difference and set quo[0] = 1. Otherwise restore rem and set quo[0] = 0.
  - The counter runs from 0 to XLEN-1. Leave ITER after XLEN steps.
- **FIX:**
  - Quotient is negated when signA XOR signB (signed ops only).
  - Remainder takes the sign of the dividend.
  - Select the quotient or the remainder by RemOpM and register it into PreIntResultM.
- **DONE:** DoneM = 1 for exactly one cycle, then go to IDLE.
- Overflow case, A = 100…0 with B = all-ones, signed: this stage produces quotient 100…0 and remainder 0. No special handling is done here; the downstream stage overrides the result.
- Early-out paths leave PreIntResultM at 0. Downstream ignores it in those cases.
- BusyE = 1 in PREP, ITER and FIX, and 0 in IDLE and DONE.

## Timing
- **Reset:** while resetn = 0 at a clock edge, state goes to IDLE. BusyE, DoneM, BZeroM, ALTBM and RemOpM are 0. AM, BM, PreIntResultM and the counter are 0.
- **Normal latency:** StartE is sampled at edge 0. PREP runs in cycle 1, ITER in cycles 2..XLEN+1, and FIX in cycle XLEN+2. DoneM = 1 in cycle XLEN+3.
- **Early-out latency:** DoneM = 1 in cycle 2.
- **Output hold:** AM, BM, RemOpM, BZeroM, ALTBM and PreIntResultM stay stable from DoneM until the next accepted StartE.
- **StartE while busy:** ignored. StartE coincident with DoneM is ignored; it is accepted on the next IDLE cycle.
- **FlushE:** takes priority over every other transition. Next state is IDLE, with no DoneM and BusyE = 0 next cycle. Registered outputs are not cleared.
- **FlushE together with StartE in IDLE:** the start is not accepted.
- **resetn low mid-operation:** the reset values above apply on the next edge. No DoneM is generated.

## Structure
- The state enum typedef (divintstate_t: IDLE, PREP, ITER, FIX, DONE) goes in the shared cvw package next to the existing divider state types.
- The counter width is $clog2(P.XLEN)+1 and is derived locally.
- One combinational sub-module, divremsqrtintstep, performs a single restoring step. Inputs: rem, quo, |B|. Outputs: next rem, next quo.
- The top level holds the FSM, the sign/magnitude prep and the FIX logic.

## Test plan
All scenarios use XLEN = 64.
- **Unsigned divide:** A = 100, B = 7, RemOpE = 0 → DoneM at cycle 67; PreIntResultM[63:0] = 14.
- **Signed remainder:** A = -100, B = 7, SignedE = 1, RemOpE = 1 → PreIntResultM[63:0] = -2, with bits 67:64 all-ones.
- **Divide by zero:** B = 0 → BZeroM = 1 and DoneM at cycle 2; AM = A is held.
- **Small numerator:**
  - A = 3, B = 5 → ALTBM = 1 and DoneM at cycle 2.
  - Signed A = -3, B = 5 → ALTBM = 1.
- **Overflow:** A = 0x8000_0000_0000_0000, B = all-ones, signed, RemOpE = 0 → PreIntResultM[63:0] = 0x8000_0000_0000_0000 at cycle 67.
- **Flush and reset mid-operation:**
  - FlushE at cycle 20 → BusyE = 0 at cycle 21, and no DoneM ever appears.
  - A new StartE at cycle 22 completes normally.
  - resetn low at cycle 30 → all outputs at their reset values.
